alu_operand_sequencer: RTL and testbench

- Upstream/downstream wrapper stage for the combinational ALU (WIDTH-bit; ALUControl[2:0]; ALUFlags = {V,C,N,Z}).
- Collects operand A, operand B and the opcode as three words over a valid/ready input stream, drives them to the ALU, and registers Result and Flags.
- Presents the registered result on a valid/ready output stream.
- Optional chain mode feeds the previous result back as the next operand A, so the lab board can run accumulator-style calculations from switches and buttons.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_operand_sequencer.sv | 117 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

  // FSM state; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } seq_state_t;

  // ALUControl opcode map.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_ASR = 3'd7;

  // Bit positions inside ALUFlags = {V,C,N,Z}.
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode words over a valid/ready stream, holds them
// stable on the ALU inputs for one execute cycle, and offers the registered
// result/flags on a valid/ready output stream. Chain mode recycles the
// result as the next operand A.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 chain,
  input  logic                 abort,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [3:0]           alu_flags,
  output logic [WIDTH-1:0]     out_result,
  output logic [3:0]           out_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           state_dbg,
  output logic [CNT_WIDTH-1:0] op_count
);

  seq_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctrl_q;
  logic             in_xfer;
  logic             out_xfer;

  // Ready depends on state only, so there is no valid->ready loop upstream.
  always_comb begin
    in_ready = 1'b0;
    if (state == S_A || state == S_B || state == S_OP) begin
      in_ready = 1'b1;
    end
  end

  // Handshake qualifiers and direct register-to-port drives.
  always_comb begin
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_ready & out_valid;
    alu_a     = a_q;
    alu_b     = b_q;
    alu_ctrl  = ctrl_q;
    state_dbg = state;
  end

  // Sequencer FSM with operand, result, flag and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      out_result <= '0;
      out_flags  <= '0;
      out_valid  <= 1'b0;
      op_count   <= '0;
    end else if (abort) begin
      // Abort wins over both handshakes; captured data is kept.
      state     <= S_A;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_A: begin
          if (in_xfer) begin
            a_q   <= in_data;
            state <= S_B;
          end
        end
        S_B: begin
          if (in_xfer) begin
            b_q   <= in_data;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (in_xfer) begin
            ctrl_q <= in_data[2:0];
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_result <= alu_result;
          out_flags  <= alu_flags;
          op_count   <= op_count + CNT_WIDTH'(1);
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
            if (chain) begin
              a_q   <= out_result;
              state <= S_B;
            end else begin
              state <= S_A;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a behavioural ALU sits beside the DUT as
// at the parent level, a transaction-level model predicts every output each
// cycle, and directed vectors carry hand-computed literal expectations.
module tb_alu_operand_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          chain;
  logic          abort;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_ctrl;
  logic [W-1:0]  alu_result;
  logic [3:0]    alu_flags;
  logic [W-1:0]  out_result;
  logic [3:0]    out_flags;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    state_dbg;
  logic [CW-1:0] op_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .chain(chain), .abort(abort), .alu_a(alu_a),
    .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_flags(alu_flags), .out_result(out_result), .out_flags(out_flags),
    .out_valid(out_valid), .out_ready(out_ready), .state_dbg(state_dbg),
    .op_count(op_count)
  );

  // Reference ALU: returns {V,C,N,Z, result}; C on subtract means no borrow.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       v;
    logic       c;
    v = 1'b0;
    c = 1'b0;
    s = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0];
        c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a << b;
      3'd6: r = a >> b;
      default: r = $signed(a) >>> b;
    endcase
    return {v, c, r[7], (r == 8'h00), r};
  endfunction

  // The ALU that the parent level would place next to the sequencer.
  assign {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which word is awaited next, what was collected,
  // and what the last completed operation produced.
  int          m_step;     // 0:A 1:B 2:op 3:execute 4:result offered
  logic [7:0]  m_a, m_b, m_res;
  logic [2:0]  m_op;
  logic [3:0]  m_flags;
  int unsigned m_ops;
  bit          m_known = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_ops = 0;
      m_known = 1;
    end else if (m_known) begin
      if (abort) begin
        m_step = 0;
      end else if (m_step == 0 && in_valid) begin
        m_a = in_data; m_step = 1;
      end else if (m_step == 1 && in_valid) begin
        m_b = in_data; m_step = 2;
      end else if (m_step == 2 && in_valid) begin
        m_op = in_data[2:0]; m_step = 3;
      end else if (m_step == 3) begin
        {m_flags, m_res} = alu_ref(m_a, m_b, m_op);
        m_ops = m_ops + 1;
        m_step = 4;
      end else if (m_step == 4 && out_ready) begin
        if (chain) begin
          m_a = m_res; m_step = 1;
        end else begin
          m_step = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("m_state", 32'(state_dbg), 32'(m_step));
      chk("m_in_ready", 32'(in_ready), 32'(m_step < 3));
      chk("m_out_valid", 32'(out_valid), 32'(m_step == 4));
      chk("m_alu_a", 32'(alu_a), 32'(m_a));
      chk("m_alu_b", 32'(alu_b), 32'(m_b));
      chk("m_alu_ctrl", 32'(alu_ctrl), 32'(m_op));
      chk("m_out_result", 32'(out_result), 32'(m_res));
      chk("m_out_flags", 32'(out_flags), 32'(m_flags));
      chk("m_op_count", 32'(op_count), 32'(m_ops % 256));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    bit done = 0;
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!done && n < 20) begin
      done = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!done) chk("in_handshake", 32'(in_ready), 32'd1);
  endtask

  // Send optional A, then B and opcode; check the two-edge output latency.
  task automatic run_op(input bit send_a, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op);
    if (send_a) send_word(a);
    send_word(b);
    send_word({5'b0, op});
    chk("lat_exec", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic take_out(input bit c);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk("out_wait", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    chain     = c;
    tick();
    out_ready = 1'b0;
    chain     = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 8'h0F, b: 8'h55, op: 3'd2, res: 8'hF0, flg: 4'b0010};
    vecs[1] = '{a: 8'hF0, b: 8'h3C, op: 3'd3, res: 8'h30, flg: 4'b0000};
    vecs[2] = '{a: 8'hF0, b: 8'h0F, op: 3'd4, res: 8'hFF, flg: 4'b0010};
    vecs[3] = '{a: 8'h81, b: 8'h01, op: 3'd5, res: 8'h02, flg: 4'b0000};
    vecs[4] = '{a: 8'h80, b: 8'h02, op: 3'd7, res: 8'hE0, flg: 4'b0010};
    vecs[5] = '{a: 8'hFF, b: 8'h01, op: 3'd0, res: 8'h00, flg: 4'b0101};
    vecs[6] = '{a: 8'h00, b: 8'h01, op: 3'd1, res: 8'hFF, flg: 4'b0010};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data   = 8'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      chain     = 1'($urandom);
      abort     = 1'($urandom);
      tick();
    end
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    in_data = '0; in_valid = 0; out_ready = 0; chain = 0; abort = 0;
    rst_n = 1'b1;
    tick();

    // Add with signed overflow.
    run_op(1, 8'h7F, 8'h01, 3'd0);
    chk("add_result", 32'(out_result), 32'h80);
    chk("add_flags", 32'(out_flags), 32'b1010);
    chk("add_count", 32'(op_count), 32'd1);

    // Chain: result becomes A, then logical shift right by one.
    take_out(1);
    chk("chain_state", 32'(state_dbg), 32'd1);
    chk("chain_alu_a", 32'(alu_a), 32'h80);
    run_op(0, 8'h00, 8'h01, 3'd6);
    chk("shr_result", 32'(out_result), 32'h40);
    chk("shr_flags", 32'(out_flags), 32'b0000);
    take_out(0);

    // Subtract to zero, then hold the result under backpressure.
    run_op(1, 8'h05, 8'h05, 3'd1);
    chk("sub_result", 32'(out_result), 32'h00);
    chk("sub_flags", 32'(out_flags), 32'b0101);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(out_result), 32'h00);
      chk("bp_flags", 32'(out_flags), 32'b0101);
    end
    in_valid = 1'b0;
    take_out(0);
    chk("bp_release_state", 32'(state_dbg), 32'd0);

    // Abort in the opcode phase alongside a valid opcode word.
    send_word(8'h10);
    send_word(8'h20);
    in_data = 8'h03; in_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_op_state", 32'(state_dbg), 32'd0);
    chk("abort_op_ctrl", 32'(alu_ctrl), 32'd1);
    chk("abort_op_count", 32'(op_count), 32'd3);

    // Abort during the execute cycle.
    send_word(8'h10);
    send_word(8'h20);
    send_word(8'h04);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ex_state", 32'(state_dbg), 32'd0);
    chk("abort_ex_result", 32'(out_result), 32'h00);
    chk("abort_ex_count", 32'(op_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_ex_valid", 32'(out_valid), 32'd0);
    end

    // Remaining opcodes and carry/borrow corners.
    foreach (vecs[i]) begin
      run_op(1, vecs[i].a, vecs[i].b, vecs[i].op);
      chk("vec_result", 32'(out_result), 32'(vecs[i].res));
      chk("vec_flags", 32'(out_flags), 32'(vecs[i].flg));
      take_out(0);
    end
    chk("vec_count", 32'(op_count), 32'd10);

    // Counter wrap.
    for (int i = 0; i < 245; i++) begin
      run_op(1, 8'(i), 8'(i + 3), 3'(i));
      take_out(0);
    end
    chk("cnt_max", 32'(op_count), 32'd255);
    run_op(1, 8'h01, 8'h02, 3'd0);
    chk("cnt_wrap", 32'(op_count), 32'd0);
    take_out(0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
